speech256_top: RTL and testbench



---
 rtl/speech256_pkg.sv | 61 ++++++
 rtl/speech256_source.sv | 53 +++++
 rtl/speech256_top.sv | 152 +++++++++++++++
 tb/tb_speech256_top.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/speech256_pkg.sv
// speech256_pkg
//   Shared definitions for the allophone speech core: pause durations,
//   excitation amplitudes, LFSR seed, sequencer state enum, the allophone
//   decode function and the 16-bit output saturation helper.
//   No ports (package).
package speech256_pkg;

  // Pause allophones 0x00..0x04 and their lengths in frames
  localparam logic [4:0] PAUSE0_FRAMES = 5'd1;
  localparam logic [4:0] PAUSE1_FRAMES = 5'd3;
  localparam logic [4:0] PAUSE2_FRAMES = 5'd5;
  localparam logic [4:0] PAUSE3_FRAMES = 5'd10;
  localparam logic [4:0] PAUSE4_FRAMES = 5'd20;

  // Excitation amplitudes (18-bit signed filter domain)
  localparam logic signed [17:0] AMP_PULSE = 18'sd4096;
  localparam logic signed [17:0] AMP_NOISE = 18'sd2048;

  localparam logic [14:0] LFSR_SEED = 15'h0001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  typedef struct packed {
    logic       pause;   // silent allophone, x = 0
    logic       voiced;  // pulse train instead of noise
    logic [5:0] period;  // pitch period in samples
    logic [2:0] k;       // filter shift
    logic [4:0] frames;  // duration in frames
  } allo_t;

  function automatic allo_t decode(input logic [5:0] code);
    allo_t a;
    a.pause  = (code <= 6'h04);
    a.voiced = ~code[5];
    a.period = 6'd32 + {1'b0, code[4:0]};
    a.k      = a.pause ? 3'd1 : (3'd1 + {1'b0, code[4:3]});
    case (code)
      6'h00:   a.frames = PAUSE0_FRAMES;
      6'h01:   a.frames = PAUSE1_FRAMES;
      6'h02:   a.frames = PAUSE2_FRAMES;
      6'h03:   a.frames = PAUSE3_FRAMES;
      6'h04:   a.frames = PAUSE4_FRAMES;
      default: a.frames = 5'd4 + {2'b00, code[2:0]};
    endcase
    return a;
  endfunction

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'h7fff;
    end else if (v < -18'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/speech256_source.sv
// speech256_source
//   Excitation generator: pitch counter for voiced allophones, 15-bit LFSR
//   for unvoiced ones, and the excitation mux. x is registered and changes
//   only on a sample tick.
// Ports:
//   clk, rst_an        clock, synchronous active-low reset
//   start              allophone accepted this cycle (restarts pitch counter)
//   tick               sample tick
//   pause, voiced      excitation selection for the current allophone
//   period             pitch period in samples
//   x                  18-bit signed excitation sample
module speech256_source
  import speech256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_an,
  input  logic        start,
  input  logic        tick,
  input  logic        pause,
  input  logic        voiced,
  input  logic [5:0]  period,
  output logic [17:0] x
);

  logic [5:0]  pitch_cnt_reg;
  logic [14:0] lfsr_reg;
  logic [14:0] lfsr_next;

  assign lfsr_next = {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      pitch_cnt_reg <= '0;
      lfsr_reg      <= LFSR_SEED;
      x             <= '0;
    end else if (start) begin
      // Each allophone begins its pulse train on its very first sample
      pitch_cnt_reg <= '0;
    end else if (tick) begin
      if (pause) begin
        x <= '0;
      end else if (voiced) begin
        x             <= (pitch_cnt_reg == 6'd0) ? AMP_PULSE : '0;
        pitch_cnt_reg <= (pitch_cnt_reg == period - 6'd1) ? 6'd0 : pitch_cnt_reg + 6'd1;
      end else begin
        // The LFSR only moves on unvoiced ticks and is never reseeded
        lfsr_reg <= lfsr_next;
        x        <= lfsr_next[0] ? AMP_NOISE : -AMP_NOISE;
      end
    end
  end

endmodule

// File: rtl/speech256_top.sv
// speech256_top
//   Allophone-driven speech synthesizer. Accepts 6-bit codes over a
//   strobe/ready handshake, plays each as a timed run of excitation samples
//   through a one-pole low-pass and emits signed 16-bit samples plus a
//   1-bit sigma-delta stream.
// Build option: define SPEECH256_PWM_EN to include the sigma-delta DAC;
//   without it pwm_out is tied to 0.
// Ports:
//   clk, rst_an   clock, synchronous active-low reset
//   data_in       allophone code
//   data_stb      load strobe, honoured only while ldq=1
//   ldq           load request (1 = idle)
//   sample_out    signed output sample
//   sample_stb    one-cycle pulse when sample_out updates
//   pwm_out       sigma-delta DAC bit
module speech256_top
  import speech256_pkg::*;
#(
  parameter int SAMPLE_DIV    = 256,
  parameter int FRAME_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        rst_an,
  input  logic [5:0]  data_in,
  input  logic        data_stb,
  output logic        ldq,
  output logic [15:0] sample_out,
  output logic        sample_stb,
  output logic        pwm_out
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SAMP_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;

  state_t             state_reg;
  allo_t              allo_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [SAMP_W-1:0]  samp_cnt_reg;
  logic [4:0]         frame_cnt_reg;
  logic               last_reg;
  logic               tick;
  logic               tick_reg;
  logic               accept;
  logic [17:0]        x_w;

  logic signed [17:0] y_reg;
  logic signed [17:0] diff;
  logic signed [17:0] y_next;

  assign tick   = (state_reg == ST_PLAY) && (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1));
  // Registered ldq gates acceptance, so a strobe on the edge where ldq rises is dropped
  assign accept = (state_reg == ST_IDLE) && ldq && data_stb;

  // Sequencer
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      state_reg     <= ST_IDLE;
      ldq           <= 1'b1;
      allo_reg      <= '0;
      div_cnt_reg   <= '0;
      samp_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      last_reg      <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      tick_reg <= tick;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            allo_reg      <= decode(data_in);
            state_reg     <= ST_PLAY;
            ldq           <= 1'b0;
            div_cnt_reg   <= '0;
            samp_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
            last_reg      <= 1'b0;
          end
        end
        ST_PLAY: begin
          div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
          if (tick) begin
            if (samp_cnt_reg == SAMP_W'(FRAME_SAMPLES - 1)) begin
              samp_cnt_reg  <= '0;
              frame_cnt_reg <= frame_cnt_reg + 5'd1;
              if (frame_cnt_reg == allo_reg.frames - 5'd1) begin
                last_reg <= 1'b1;
              end
            end else begin
              samp_cnt_reg <= samp_cnt_reg + SAMP_W'(1);
            end
          end
          // The final sample is two edges behind its tick; leave once it is out
          if (sample_stb && last_reg) begin
            state_reg <= ST_IDLE;
            ldq       <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ldq       <= 1'b1;
        end
      endcase
    end
  end

  speech256_source u_source (
    .clk    (clk),
    .rst_an (rst_an),
    .start  (accept),
    .tick   (tick),
    .pause  (allo_reg.pause),
    .voiced (allo_reg.voiced),
    .period (allo_reg.period),
    .x      (x_w)
  );

  // One-pole low-pass; x_w was refreshed on the tick edge, so filter one edge later
  assign diff   = $signed(x_w) - y_reg;
  assign y_next = y_reg + (diff >>> allo_reg.k);

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      y_reg      <= '0;
      sample_out <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= tick_reg;
      if (tick_reg) begin
        y_reg      <= y_next;
        sample_out <= sat16(y_next);
      end
    end
  end

`ifdef SPEECH256_PWM_EN
  // First-order sigma-delta on the offset-binary top byte
  logic [8:0] pwm_acc_reg;

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      pwm_acc_reg <= '0;
    end else begin
      pwm_acc_reg <= {1'b0, pwm_acc_reg[7:0]} + {1'b0, sample_out[15:8] ^ 8'h80};
    end
  end

  assign pwm_out = pwm_acc_reg[8];
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_speech256_top.sv
// tb_speech256_top
//   Self-checking bench for speech256_top. A behavioural model computes each
//   expected sample from the allophone rules (duration table, pitch period,
//   LFSR recurrence, filter equation); the bench checks every sample value
//   and strobe time, ldq handshake timing, idle behaviour, PWM duty and
//   mid-play reset. SAMPLE_DIV is reduced to keep the run short.
module tb_speech256_top;

  localparam int SDIV = 4;
  localparam int FSAMP = 64;

  logic        clk;
  logic        rst_an;
  logic [5:0]  data_in;
  logic        data_stb;
  logic        ldq;
  logic [15:0] sample_out;
  logic        sample_stb;
  logic        pwm_out;

  int errors = 0;
  int checks = 0;
  int rises = 0;

  // Reference model state
  int y_m;
  int lfsr_m;
  int s_m;

  speech256_top #(.SAMPLE_DIV(SDIV), .FRAME_SAMPLES(FSAMP)) dut (
    .clk        (clk),
    .rst_an     (rst_an),
    .data_in    (data_in),
    .data_stb   (data_stb),
    .ldq        (ldq),
    .sample_out (sample_out),
    .sample_stb (sample_stb),
    .pwm_out    (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int frames_of(input int code);
    case (code)
      0: return 1;
      1: return 3;
      2: return 5;
      3: return 10;
      4: return 20;
      default: return 4 + (code & 7);
    endcase
  endfunction

  // Next expected sample of an allophone, idx = sample number within it
  task automatic model_step(input int code, input int idx, output int s);
    int x;
    int k;
    int p;
    if (code <= 4) begin
      x = 0;
      k = 1;
    end else begin
      k = 1 + ((code >> 3) & 3);
      if (((code >> 5) & 1) == 0) begin
        p = 32 + (code & 31);
        x = ((idx % p) == 0) ? 4096 : 0;
      end else begin
        lfsr_m = ((lfsr_m << 1) & 32'h7fff) | (((lfsr_m >> 14) ^ (lfsr_m >> 13)) & 1);
        x = (lfsr_m & 1) ? 2048 : -2048;
      end
    end
    y_m = y_m + ((x - y_m) >>> k);
    if (y_m > 32767) s = 32767;
    else if (y_m < -32768) s = -32768;
    else s = y_m;
    s_m = s;
  endtask

  task automatic play(input int code, input bit spurious);
    int total;
    int idx;
    int cyc;
    int s;
    total = frames_of(code) * FSAMP;
    check("ldq_ready", ldq, 1);
    data_in  = 6'(code);
    data_stb = 1'b1;
    @(negedge clk);
    data_stb = 1'b0;
    check("ldq_accept", ldq, 0);
    idx = 0;
    cyc = 0;
    while (ldq == 1'b0 && cyc < total * SDIV + 16) begin
      @(negedge clk);
      cyc++;
      data_stb = 1'b0;
      if (sample_stb) begin
        model_step(code, idx, s);
        check("sample", $signed(sample_out), s);
        check("stb_time", cyc, (idx + 1) * SDIV + 1);
        if (((code >> 5) & 1) == 1) begin
          check("unv_bound", int'($signed(sample_out) <= 2048 && $signed(sample_out) >= -2048), 1);
        end
        idx++;
        // Strobe on the edge where ldq rises must be ignored
        if (spurious && idx == total) begin
          data_in  = 6'($urandom_range(0, 63));
          data_stb = 1'b1;
        end
      end else if (spurious && ldq == 1'b0 && $urandom_range(0, 7) == 0) begin
        data_in  = 6'($urandom_range(0, 63));
        data_stb = 1'b1;
      end
    end
    data_stb = 1'b0;
    if (ldq == 1'b1) rises++;
    check("n_samples", idx, total);
    check("ldq_rise", cyc, total * SDIV + 2);
    @(negedge clk);
    check("ldq_hold", ldq, 1);
    $display("code=0x%02h frames=%0d samples=%0d last=%0d", code, frames_of(code), idx, s_m);
  endtask

  // Idle window: no strobes, held sample, PWM ones count = offset top byte
  task automatic idle_window(input string tag);
    int ones;
    int stbs;
    int bad;
    int exp_ones;
    ones = 0;
    stbs = 0;
    bad  = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ones += int'(pwm_out);
      stbs += int'(sample_stb);
      if ($signed(sample_out) != s_m || ldq != 1'b1) bad++;
    end
`ifdef SPEECH256_PWM_EN
    exp_ones = ((s_m >> 8) & 255) ^ 128;
`else
    exp_ones = 0;
`endif
    check({tag, "_stb"}, stbs, 0);
    check({tag, "_hold"}, bad, 0);
    check({tag, "_pwm"}, ones, exp_ones);
    $display("idle %s sample=%0d pwm_ones=%0d", tag, s_m, ones);
  endtask

  initial begin
    int seq [5];
    int code;
    rst_an   = 1'b0;
    data_stb = 1'b0;
    data_in  = '0;
    y_m      = 0;
    lfsr_m   = 1;
    s_m      = 0;
    repeat (3) @(negedge clk);
    check("rst_ldq", ldq, 1);
    check("rst_sample", sample_out, 0);
    check("rst_stb", sample_stb, 0);
    check("rst_pwm", pwm_out, 0);
    rst_an = 1'b1;
    @(negedge clk);
    idle_window("after_reset");

    play(6'h00, 1'b0);
    idle_window("pause0");
    play(6'h13, 1'b0);
    play(6'h2D, 1'b0);
    idle_window("after_2d");

    // Repeated strobes during PLAY must not disturb anything
    seq = '{6'h13, 6'h02, 6'h0D, 6'h13, 6'h03};
    rises = 0;
    foreach (seq[i]) play(seq[i], 1'b1);
    check("seq_rises", rises, 5);

    // Abort mid-play
    data_in  = 6'h13;
    data_stb = 1'b1;
    @(negedge clk);
    data_stb = 1'b0;
    repeat (600) @(negedge clk);
    rst_an = 1'b0;
    @(negedge clk);
    check("abort_ldq", ldq, 1);
    check("abort_sample", sample_out, 0);
    check("abort_stb", sample_stb, 0);
    check("abort_pwm", pwm_out, 0);
    rst_an = 1'b1;
    y_m    = 0;
    lfsr_m = 1;
    s_m    = 0;
    @(negedge clk);
    idle_window("after_abort");

    for (int n = 0; n < 6; n++) begin
      code = int'($urandom_range(0, 63));
      play(code, n[0]);
    end
    idle_window("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
